leading_digit_counter_pipe: RTL

//  Parametrised, pipelined leading-digit counter for add/subtract normalisation.

---
 rtl/leading_digit_counter_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/leading_digit_counter_pipe.sv
// Pipelined leading-digit counter for add/subtract normalisation.
// Stage 1 counts per segment; stage 2 combines segments into a total.
module leading_digit_counter_pipe #(
   parameter int W     = 26,
   parameter int CNT_W = 5,
   parameter int SEG   = 8,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     data_i,
   input  logic             mode_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count_o,
   output logic             all_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int NSEG = (W + SEG - 1) / SEG;
   localparam int PW   = NSEG * SEG;
   localparam int LAST = W - (NSEG - 1) * SEG;
   localparam int SC_W = $clog2(SEG + 1);

   logic                       s1_valid;
   logic [NSEG-1:0][SC_W-1:0]  s1_cnt;
   logic [NSEG-1:0]            s1_all;
   logic [TAG_W-1:0]           s1_tag;

   logic                       s1_adv;
   logic                       s2_adv;

   logic [PW-1:0]              pad;
   logic [NSEG-1:0][SC_W-1:0]  seg_cnt;
   logic [NSEG-1:0]            seg_all;
   logic                       run;

   logic [CNT_W-1:0]           sum;
   logic                       sum_all;
   logic                       live;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;

   // Per-segment leading-ones count; zero padding at the LSB end
   // stops the count inside the short last segment.
   always_comb begin
      pad     = '0;
      seg_cnt = '0;
      seg_all = '0;
      run     = 1'b0;
      pad[PW-1 -: W] = mode_i ? data_i : ~data_i;
      for (int k = 0; k < NSEG; k++) begin
         run = 1'b1;
         for (int j = 0; j < SEG; j++) begin
            if (run && pad[PW-1-k*SEG-j])
               seg_cnt[k] = seg_cnt[k] + SC_W'(1);
            else
               run = 1'b0;
         end
         seg_all[k] = (seg_cnt[k] ==
                       SC_W'(k == NSEG-1 ? LAST : SEG));
      end
   end

   // Sum leading all-ones segments plus the first partial one.
   always_comb begin
      sum     = '0;
      live    = 1'b1;
      sum_all = &s1_all;
      for (int k = 0; k < NSEG; k++) begin
         if (live)
            sum = sum + CNT_W'(s1_cnt[k]);
         if (!s1_all[k])
            live = 1'b0;
      end
   end

   // Stage-1 register: loads only on an accepted operand.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_cnt   <= '0;
         s1_all   <= '0;
         s1_tag   <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cnt <= seg_cnt;
            s1_all <= seg_all;
            s1_tag <= tag_i;
         end
      end
   end

   // Output register: holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         count_o   <= '0;
         all_o     <= 1'b0;
         tag_o     <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            count_o <= sum;
            all_o   <= sum_all;
            tag_o   <= s1_tag;
         end
      end
   end

endmodule
